clock_divider: RTL and testbench

CLOCK_DIVIDER -- requirements
Module: clock_divider

---
 rtl/clock_divider.sv | 22 ++
 tb/tb_clock_divider.sv | 73 +++++++
 2 files changed

// File: rtl/clock_divider.sv
// clock_divider: one-cycle strobe every VALUE clkIN cycles, synchronous active-high reset.
module clock_divider #(
  parameter int VALUE = 5
) (
  input  logic clkIN,
  input  logic resetIN,
  output logic clkOUT = 1'b0
);
  localparam int W = (VALUE > 1) ? $clog2(VALUE) : 1;
  localparam logic [W-1:0] LAST = W'(VALUE - 1);
  if (VALUE < 1) begin : g_bad_value
    $error("clock_divider: VALUE must be >= 1");
  end
  logic [W-1:0] count = '0;
  logic wrap;
  always_comb wrap = (count == LAST);
  // The strobe is registered on the same edge that wraps the counter.
  always_ff @(posedge clkIN) begin
    count  <= resetIN ? '0 : (wrap ? '0 : count + 1'b1);
    clkOUT <= resetIN ? 1'b0 : wrap;
  end
endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider: random and directed reset patterns against a phase-arithmetic model.
module tb_clock_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic o1, o2, o5, o7;
  int checks = 0;
  int failures = 0;
  int k = 0;
  always #5 clk = ~clk;
  clock_divider #(.VALUE(1)) u1 (.clkIN(clk), .resetIN(rst), .clkOUT(o1));
  clock_divider #(.VALUE(2)) u2 (.clkIN(clk), .resetIN(rst), .clkOUT(o2));
  clock_divider #(.VALUE(5)) u5 (.clkIN(clk), .resetIN(rst), .clkOUT(o5));
  clock_divider #(.VALUE(7)) u7 (.clkIN(clk), .resetIN(rst), .clkOUT(o7));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (k=%0d t=%0t)", tag, obs, exp, k, $time);
    end
  endtask
  // k counts edges with reset low since the last reset; a strobe is due whenever k is a nonzero multiple of VALUE.
  function automatic logic due(input int v);
    return (k > 0) && (k % v == 0);
  endfunction
  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    k = r ? 0 : k + 1;
    #1;
    check("out_v1", 32'(o1), 32'(due(1)));
    check("out_v2", 32'(o2), 32'(due(2)));
    check("out_v5", 32'(o5), 32'(due(5)));
    check("out_v7", 32'(o7), 32'(due(7)));
    check("cnt_v5", 32'(u5.count), 32'(k % 5));
    check("cnt_v7_max", 32'(u7.count <= 3'd6), 32'd1);
  endtask
  initial begin
    int strobes;
    logic prev;
    #1;
    check("pwrup_v5", 32'(o5), 32'd0);
    check("pwrup_v7", 32'(o7), 32'd0);
    repeat (3) step(1'b1);
    repeat (12) step(1'b0);
    step(1'b1);
    strobes = 0;
    prev = 1'b0;
    for (int i = 0; i < 125; i++) begin
      step(1'b0);
      check("no_double_v5", 32'(o5 && prev), 32'd0);
      strobes += int'(o5);
      prev = o5;
    end
    check("strobes_125", 32'(strobes), 32'd25);
    step(1'b1);
    repeat (3) step(1'b0);
    step(1'b1);
    repeat (6) step(1'b0);
    step(1'b1);
    repeat (4) step(1'b0);
    step(1'b1);
    check("due_rst_v5", 32'(o5), 32'd0);
    strobes = 0;
    for (int i = 0; i < 70; i++) begin
      step(1'b0);
      strobes += int'(o7);
    end
    check("strobes_v7_70", 32'(strobes), 32'd10);
    for (int i = 0; i < 500; i++) step($urandom_range(0, 15) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
